// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V funct3 codes, width constants, LSU state enum and decode helpers
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int STRB_W = XLEN / 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } lsu_state_e;

  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // Low two funct3 bits encode access size for both loads and stores.
  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [2:0] f3);
    case (f3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - control-side request/response bus and memory-side bus of the LSU
interface lsu_req_if;
  import riscv_pkg::*;

  logic            req_valid;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [2:0]      req_funct3;
  logic            req_ready;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface lsu_mem_if;
  import riscv_pkg::*;

  logic              mem_valid;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ready;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores and lane extraction plus sign/zero extension for loads
module lsu_align
  import riscv_pkg::*;
(
  input  logic              we,
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [STRB_W-1:0] wstrb,
  output logic [XLEN-1:0]   wdata_lane,
  output logic [XLEN-1:0]   rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_en;

  always_comb begin
    wstrb      = '0;
    wdata_lane = '0;
    if (we) begin
      case (funct3[1:0])
        2'b00: begin
          wstrb      = 4'b0001 << addr_lo;
          wdata_lane = XLEN'(wdata[7:0]) << {addr_lo, 3'b000};
        end
        // Halfword lanes follow addr[1] only, so addr[0] is dropped when not trapping.
        2'b01: begin
          wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
          wdata_lane = XLEN'(wdata[15:0]) << {addr_lo[1], 4'b0000};
        end
        default: begin
          wstrb      = 4'b1111;
          wdata_lane = wdata;
        end
      endcase
    end
  end

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    sign_en  = ~funct3[2];
    case (funct3[1:0])
      2'b00:   rdata_ext = {{24{byte_sel[7] & sign_en}}, byte_sel};
      2'b01:   rdata_ext = {{16{half_sel[15] & sign_en}}, half_sel};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit: request capture, memory handshake with timeout, response; optional LSU_MISALIGN_TRAP_EN
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic       clk,
  input logic       rst_n,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;

  logic              trap;
  logic [1:0]        al_addr_lo;
  logic [2:0]        al_funct3;
  logic [STRB_W-1:0] al_wstrb;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_rdata;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = misaligned(req.req_addr[1:0], req.req_funct3);
`else
  assign trap = 1'b0;
`endif

  // The aligner sees live request fields while idle and the captured ones afterwards.
  assign al_addr_lo = (state_q == IDLE) ? req.req_addr[1:0] : addr_lo_q;
  assign al_funct3  = (state_q == IDLE) ? req.req_funct3    : funct3_q;
  assign cnt_inc    = cnt_q + 1'b1;

  lsu_align u_align (
    .we         (req.req_we),
    .addr_lo    (al_addr_lo),
    .funct3     (al_funct3),
    .wdata      (req.req_wdata),
    .rdata      (mem.mem_rdata),
    .wstrb      (al_wstrb),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_lo_d   = addr_lo_q;
    funct3_d    = funct3_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req.req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          addr_lo_d   = req.req_addr[1:0];
          funct3_d    = req.req_funct3;
          if (!funct3_legal(req.req_we, req.req_funct3) || trap) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = ACCESS;
            cnt_d       = '0;
            mem_valid_d = 1'b1;
            mem_we_d    = req.req_we;
            mem_addr_d  = {req.req_addr[XLEN-1:2], 2'b00};
            mem_wdata_d = al_wdata;
            mem_wstrb_d = al_wstrb;
          end
        end
      end
      ACCESS: begin
        if (mem.mem_ready) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_we_q ? '0 : al_rdata;
          {mem_valid_d, mem_we_d, mem_addr_d, mem_wdata_d, mem_wstrb_d} = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          {mem_valid_d, mem_we_d, mem_addr_d, mem_wdata_d, mem_wstrb_d} = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_lo_q   <= '0;
      funct3_q    <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_lo_q   <= addr_lo_d;
      funct3_q    <= funct3_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign req.req_ready = req_ready_q;
  assign req.rsp_valid = rsp_valid_q;
  assign req.rsp_err   = rsp_err_q;
  assign req.rsp_rdata = rsp_rdata_q;
  assign mem.mem_valid = mem_valid_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - cycle-accurate expectation timeline for the load/store unit with directed accesses
module tb_load_store_unit;

  localparam int TMO = 8;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   done = 0;

  typedef struct packed {
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } obs_t;

  // Expected outputs per cycle; cycles with no entry must look idle.
  obs_t exp_q [int];

  lsu_req_if req_bus ();
  lsu_mem_if mem_bus ();

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_bus),
    .mem   (mem_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.req_ready = 1'b1;
    return o;
  endfunction

  // Reference rules: an access covers `size` bytes starting at the size-aligned lane base.
  function automatic int unsigned acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int unsigned lane_base(input logic [31:0] addr, input logic [2:0] f3);
    int unsigned s;
    s = acc_size(f3);
    return (addr % 4) / s * s;
  endfunction

  function automatic logic [3:0] m_strb(input logic [31:0] addr, input logic [2:0] f3);
    logic [3:0] r;
    int unsigned b;
    r = '0;
    b = lane_base(addr, f3);
    for (int i = 0; i < 4; i++)
      if (i >= b && i < b + acc_size(f3)) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int unsigned b;
    r = '0;
    b = lane_base(addr, f3);
    for (int j = 0; j < acc_size(f3); j++) r[8*(b+j) +: 8] = wd[8*j +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rd);
    logic [31:0] v;
    int unsigned b, s;
    v = '0;
    b = lane_base(addr, f3);
    s = acc_size(f3);
    for (int j = 0; j < s; j++) v[8*j +: 8] = rd[8*(b+j) +: 8];
    if (!f3[2] && s < 4 && v[8*s-1])
      for (int k = 8*s; k < 32; k++) v[k] = 1'b1;
    return v;
  endfunction

  function automatic bit m_legal(input bit we, input logic [2:0] f3);
    if (we) return f3 < 3'd3;
    return !(f3 == 3'd3 || f3 >= 3'd6);
  endfunction

  function automatic bit m_trap(input logic [31:0] addr, input logic [2:0] f3);
`ifdef LSU_MISALIGN_TRAP_EN
    return (addr % acc_size(f3)) != 0;
`else
    return (addr == 32'hFFFF_FFFF) && (f3 == 3'b111) && 1'b0;
`endif
  endfunction

  // Record the whole timeline of one access; len = cycles from accept to response.
  task automatic model_push(input int c0, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [2:0] f3, input logic [31:0] rd, input int d, output int len);
    obs_t o;
    int   n;
    if (!m_legal(we, f3) || m_trap(addr, f3)) begin
      o = '0;
      o.rsp_valid = 1'b1;
      o.rsp_err   = 1'b1;
      exp_q[c0 + 1] = o;
      len = 1;
    end else begin
      n = (d < TMO) ? d + 1 : TMO;
      for (int k = 1; k <= n; k++) begin
        o = '0;
        o.mem_valid = 1'b1;
        o.mem_we    = we;
        o.mem_addr  = addr & ~32'd3;
        o.mem_wstrb = we ? m_strb(addr, f3) : 4'b0000;
        o.mem_wdata = we ? m_wdata(addr, f3, wd) : 32'd0;
        exp_q[c0 + k] = o;
      end
      o = '0;
      o.rsp_valid = 1'b1;
      o.rsp_err   = (d >= TMO);
      o.rsp_rdata = (!we && d < TMO) ? m_load(addr, f3, rd) : 32'd0;
      exp_q[c0 + n + 1] = o;
      len = n + 1;
    end
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (cyc >= 1 && !done) begin
      e = exp_q.exists(cyc) ? exp_q[cyc] : idle_obs();
      chk("req_ready", 32'(req_bus.req_ready), 32'(e.req_ready));
      chk("rsp_valid", 32'(req_bus.rsp_valid), 32'(e.rsp_valid));
      chk("rsp_err",   32'(req_bus.rsp_err),   32'(e.rsp_err));
      chk("rsp_rdata", req_bus.rsp_rdata,      e.rsp_rdata);
      chk("mem_valid", 32'(mem_bus.mem_valid), 32'(e.mem_valid));
      chk("mem_we",    32'(mem_bus.mem_we),    32'(e.mem_we));
      chk("mem_addr",  mem_bus.mem_addr,       e.mem_addr);
      chk("mem_wdata", mem_bus.mem_wdata,      e.mem_wdata);
      chk("mem_wstrb", 32'(mem_bus.mem_wstrb), 32'(e.mem_wstrb));
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      req_bus.req_valid = 1'b0;
      mem_bus.mem_ready = 1'(k % 2);
      mem_bus.mem_rdata = $urandom;
    end
  endtask

  // d = ACCESS cycles without mem_ready before it is raised.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input logic [31:0] rd, input int d);
    int c0, len;
    @(posedge clk); #1;
    c0 = cyc;
    model_push(c0, we, addr, wd, f3, rd, d, len);
    req_bus.req_valid  = 1'b1;
    req_bus.req_we     = we;
    req_bus.req_addr   = addr;
    req_bus.req_wdata  = wd;
    req_bus.req_funct3 = f3;
    mem_bus.mem_ready  = 1'b1;
    mem_bus.mem_rdata  = $urandom;
    for (int k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      if (k == len) begin
        req_bus.req_valid = 1'b0;
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = $urandom;
      end else begin
        req_bus.req_we     = 1'($urandom);
        req_bus.req_addr   = $urandom;
        req_bus.req_wdata  = $urandom;
        req_bus.req_funct3 = 3'($urandom);
        mem_bus.mem_ready  = (k - 1 == d);
        mem_bus.mem_rdata  = (k - 1 == d) ? rd : $urandom;
      end
    end
  endtask

  task automatic reset_abort();
    int c0, len;
    @(posedge clk); #1;
    c0 = cyc;
    model_push(c0, 1'b0, 32'h300, 32'd0, 3'b010, 32'h0, 1000, len);
    req_bus.req_valid  = 1'b1;
    req_bus.req_we     = 1'b0;
    req_bus.req_addr   = 32'h300;
    req_bus.req_funct3 = 3'b010;
    mem_bus.mem_ready  = 1'b0;
    @(posedge clk); #1;
    req_bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int c = c0 + 3; c <= c0 + len; c++) exp_q.delete(c);
    #1;
    chk("async_mem_valid_drop", 32'(mem_bus.mem_valid), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n              = 1'b0;
    req_bus.req_valid  = 1'b0;
    req_bus.req_we     = 1'b0;
    req_bus.req_addr   = '0;
    req_bus.req_wdata  = '0;
    req_bus.req_funct3 = '0;
    mem_bus.mem_ready  = 1'b0;
    mem_bus.mem_rdata  = '0;

    chk("pin_lb",       m_load(32'h103, 3'b000, 32'h80FF1234), 32'hFFFFFF80);
    chk("pin_lbu",      m_load(32'h103, 3'b100, 32'h80FF1234), 32'h00000080);
    chk("pin_sh_strb",  32'(m_strb(32'h102, 3'b001)),          32'h0000000C);
    chk("pin_sh_wdata", m_wdata(32'h102, 3'b001, 32'h0000ABCD), 32'hABCD0000);
    chk("pin_lh_trunc", m_load(32'h101, 3'b001, 32'h1234F678), 32'hFFFFF678);
    chk("pin_sb_wdata", m_wdata(32'h101, 3'b000, 32'hDEADBEEF), 32'h0000EF00);

    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);

    access(1'b0, 32'h103, 32'h0, 3'b000, 32'h80FF1234, 0);
    access(1'b0, 32'h103, 32'h0, 3'b100, 32'h80FF1234, 0);
    access(1'b1, 32'h102, 32'h0000ABCD, 3'b001, 32'h0, 0);
    access(1'b0, 32'h200, 32'h0, 3'b010, 32'hCAFEF00D, 5);
    idle(2);
    access(1'b0, 32'h300, 32'h0, 3'b010, 32'h12345678, 100);
    access(1'b0, 32'h304, 32'h0, 3'b010, 32'h0BADBEEF, TMO - 1);
    access(1'b1, 32'h308, 32'h11223344, 3'b010, 32'h0, TMO);
    access(1'b0, 32'h040, 32'h0, 3'b011, 32'h55555555, 0);
    access(1'b0, 32'h040, 32'h0, 3'b110, 32'h55555555, 0);
    access(1'b0, 32'h040, 32'h0, 3'b111, 32'h55555555, 0);
    access(1'b1, 32'h040, 32'h99, 3'b011, 32'h0, 0);
    access(1'b1, 32'h040, 32'h99, 3'b100, 32'h0, 0);
    access(1'b0, 32'h102, 32'h0, 3'b010, 32'hA5A55A5A, 0);
    access(1'b0, 32'h101, 32'h0, 3'b001, 32'h1234F678, 1);
    access(1'b0, 32'h103, 32'h0, 3'b101, 32'h8234F678, 2);
    access(1'b1, 32'h101, 32'hDEADBEEF, 3'b000, 32'h0, 0);
    access(1'b1, 32'h103, 32'h00005566, 3'b001, 32'h0, 3);
    access(1'b1, 32'h104, 32'hFEEDC0DE, 3'b010, 32'h0, 1);
    access(1'b0, 32'h100, 32'h0, 3'b000, 32'h7F00007E, 0);
    access(1'b0, 32'h102, 32'h0, 3'b001, 32'h8001FFFF, 0);
    idle(2);

    reset_abort();
    idle(3);
    access(1'b0, 32'h400, 32'h0, 3'b010, 32'h13579BDF, 0);
    idle(3);

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
